// File: rtl/alu_issuer_pkg.sv
// alu_issuer shared definitions
// opcodes, status codes, FSM states, request bundle
package alu_issuer_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [5:0] OP_DIV  = 6'h03;
  localparam logic [5:0] OP_AND  = 6'h04;
  localparam logic [5:0] OP_OR   = 6'h05;
  localparam logic [5:0] OP_XOR  = 6'h06;
  localparam logic [5:0] OP_NOT  = 6'h07;
  localparam logic [5:0] OP_CMP  = 6'h08;
  localparam logic [5:0] OP_LAST = 6'h08;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  function automatic logic op_legal(
    input logic [5:0] op
  );
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_issuer_fifo.sv
// alu_req_fifo: in-order request buffer
// power-of-2 depth, pointers wrap naturally
module alu_req_fifo
  import alu_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  req_t wdata,
  output req_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  req_t            mem_q [DEPTH];
  req_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // next pointers, count and storage
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: queues ALU requests, runs the
// start/done handshake, returns result + status
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [5:0] alu_op,
  output logic       alu_start,
  input  logic [7:0] alu_result,
  input  logic       alu_done,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [5:0]    alu_op_q, alu_op_d;
  logic          start_q, start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_err_q, rsp_err_d;

  req_t req_in;
  req_t head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;

  assign req_in = {req_op, req_a, req_b};

  alu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .pop   (fifo_pop),
    .wdata (req_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ready = ~fifo_full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_start = start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

  // issue / wait / respond sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    start_d     = start_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (op_legal(head.op)) begin
            alu_a_d  = head.a;
            alu_b_d  = head.b;
            alu_op_d = head.op;
            start_d  = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT;
          end else begin
            rsp_data_d  = '0;
            rsp_err_d   = ST_ILLEGAL;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          rsp_data_d  = alu_result;
          rsp_err_d   = ST_OK;
          rsp_valid_d = 1'b1;
          start_d     = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = ST_TIMEOUT;
          rsp_valid_d = 1'b1;
          start_d     = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ST_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed vectors, scoreboard
// queue popped by an independent response monitor
module tb_alu_issuer;

  logic       clk = 0;
  logic       reset = 0;
  logic       req_valid = 0;
  logic       req_ready;
  logic [5:0] req_op = 0;
  logic [7:0] req_a = 0;
  logic [7:0] req_b = 0;
  logic [7:0] alu_a, alu_b;
  logic [5:0] alu_op;
  logic       alu_start;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       rsp_valid;
  logic       rsp_ready = 0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic       busy;

  alu_issuer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // behavioural ALU: registered done, one pulse per start
  logic       done_q = 0;
  logic       hang = 0;
  logic       force_done = 0;
  logic [7:0] res_q = 0;

  function automatic logic [7:0] alu_f(
    input logic [5:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      6'h00:   return a + b;
      6'h01:   return a - b;
      6'h02:   return a * b;
      6'h03:   return (b == 0) ? 8'hFF : a / b;
      6'h04:   return a & b;
      6'h05:   return a | b;
      6'h06:   return a ^ b;
      6'h07:   return ~a;
      6'h08:   return (a == b) ? 8'h00 : (a < b) ? 8'h01 : 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    done_q <= alu_start & ~done_q & ~hang;
    res_q  <= alu_f(alu_op, alu_a, alu_b);
  end

  assign alu_done   = done_q | force_done;
  assign alu_result = res_q;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] sb[$];
  int         hs_q[$];
  int         start_rises = 0;
  int         start_run = 0;
  int         last_run = 0;
  int         rise_cyc = 0;
  logic       start_prev = 0;
  logic       valid_prev = 0;

  // response monitor and strobe bookkeeping
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start) begin
        if (!start_prev) start_rises++;
        start_run++;
      end else begin
        if (start_run > 0) last_run = start_run;
        start_run = 0;
      end
      start_prev = alu_start;
      if (rsp_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = rsp_valid;
      if (reset && rsp_valid && rsp_ready) begin
        hs_q.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {22'b0, rsp_data, rsp_err}, 32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          chk("rsp_data", {24'b0, rsp_data}, {24'b0, e[9:2]});
          chk("rsp_err", {30'b0, rsp_err}, {30'b0, e[1:0]});
        end
      end
    end
  end

  int acc_cyc = 0;

  task automatic send(input logic [5:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [9:0] exp,
                      input bit track);
    bit acc;
    acc = 0;
    req_valid = 1;
    req_op = op;
    req_a = a;
    req_b = b;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 0;
    if (acc) begin
      acc_cyc = cyc;
      if (track) sb.push_back(exp);
    end else begin
      chk("send_accept", 0, 1);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[$];
  int   r0;
  int   h0;
  int   idx;
  bit   acc;
  logic [7:0] ev;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", alu_start, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_data", rsp_data, 0);
    reset = 1;
    @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    rsp_ready = 1;

    // ADD latency and strobe length
    send(6'h00, 8'h12, 8'h34, {8'h46, 2'b00}, 1);
    r0 = acc_cyc;
    wait_drain();
    chk("add_latency", rise_cyc - r0, 3);
    chk("add_start_len", last_run, 2);

    // SUB wrap, CMP and a few more, in order
    vecs.push_back('{6'h01, 8'h03, 8'h05, 8'hFE});
    vecs.push_back('{6'h08, 8'h09, 8'h03, 8'h02});
    vecs.push_back('{6'h02, 8'h10, 8'h11, 8'h10});
    vecs.push_back('{6'h06, 8'hA5, 8'hFF, 8'h5A});
    vecs.push_back('{6'h07, 8'h0F, 8'h00, 8'hF0});
    vecs.push_back('{6'h03, 8'h64, 8'h07, 8'h0E});
    foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].r, 2'b00}, 1);
    wait_drain();

    // backpressure: only DEPTH+1 requests get in
    rsp_ready = 0;
    idx = 0;
    req_valid = 1;
    for (int c = 0; c < 12 && idx < 8; c++) begin
      req_op = 6'h00;
      req_a = 8'(idx);
      req_b = 8'h10;
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ev = 8'h10 + 8'(idx);
        sb.push_back({ev, 2'b00});
        idx++;
      end
    end
    req_valid = 0;
    chk("bp_accepted", idx, 5);
    chk("bp_ready_low", req_ready, 0);
    hs_q.delete();
    rsp_ready = 1;
    wait_drain();
    chk("bp_rsp_count", hs_q.size(), 5);
    for (int i = 1; i < hs_q.size(); i++) begin
      chk("bp_spacing", hs_q[i] - hs_q[i-1], 4);
    end

    // illegal opcode, then a normal op
    r0 = start_rises;
    send(6'h09, 8'h11, 8'h22, {8'h00, 2'b01}, 1);
    wait_drain();
    chk("ill_no_start", start_rises, r0);
    send(6'h00, 8'h01, 8'h02, {8'h03, 2'b00}, 1);
    wait_drain();

    // stray done while idle is ignored
    force_done = 1;
    @(posedge clk);
    #1;
    force_done = 0;
    @(posedge clk);
    #1;
    chk("stray_valid", rsp_valid, 0);
    chk("stray_busy", busy, 0);

    // timeout, then recovery
    hang = 1;
    send(6'h00, 8'h05, 8'h05, {8'h00, 2'b10}, 1);
    wait_drain();
    chk("to_start_len", last_run, 16);
    hang = 0;
    send(6'h04, 8'hF0, 8'h3C, {8'h30, 2'b00}, 1);
    wait_drain();
    chk("to_next_len", last_run, 2);

    // reset mid-WAIT with entries queued
    hang = 1;
    send(6'h00, 8'h01, 8'h01, 10'h0, 0);
    send(6'h01, 8'h02, 8'h01, 10'h0, 0);
    send(6'h04, 8'h03, 8'h01, 10'h0, 0);
    send(6'h05, 8'h04, 8'h01, 10'h0, 0);
    @(posedge clk);
    #1;
    chk("mid_start_high", alu_start, 1);
    h0 = hs_q.size();
    reset = 0;
    #1;
    chk("mid_rst_start", alu_start, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1;
    hang = 0;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", req_ready, 1);
    repeat (25) @(posedge clk);
    #1;
    chk("mid_no_stale", hs_q.size(), h0);
    chk("mid_idle_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
